// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and helpers for the FIFO write arbiter   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int FIFO_DEPTH    = 32;
  localparam int FIFO_FULL_LVL = 31;

  // Successor of ptr with explicit wrap; nreq need not be a power of two.
  function automatic int next_rr(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_wr_arb_if : producer req/gnt bundle plus FIFO write-port pins   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface fifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_wr_data;
  logic               fifo_full;
  logic               fifo_rd;
  logic [PW-1:0]      owner;
  logic               busy;

  modport master (
    output req, req_data, fifo_full, fifo_rd,
    input  gnt, fifo_wr, fifo_wr_data, owner, busy
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_rd,
    output gnt, fifo_wr, fifo_wr_data, owner, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin candidate search from a pointer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic [PW-1:0]   i_rr_ptr,
  input  wire logic            i_prio_en,
  output logic                 o_valid,
  output logic [PW-1:0]        o_idx
);

  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[PW'(wrap_idx(int'(i_rr_ptr), k))]) begin
        o_valid = 1'b1;
        o_idx   = PW'(wrap_idx(int'(i_rr_ptr), k));
      end
    end
    if (i_prio_en && i_req[0]) begin
      o_valid = 1'b1;
      o_idx   = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_wr_arb : round-robin burst arbiter for the FIFO write port;     |
// |               FIFO_ARB_PRIO_EN makes requester 0 strict-high-prio.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fifo_wr_arb_if.slave bus
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CW = $clog2(BURST_LEN + 1);

  state_e            r_state, w_state_nxt;
  logic [c_PW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [c_PW-1:0]   r_owner, w_owner_nxt;
  logic [c_CW-1:0]   r_beat_cnt, w_cnt_nxt, w_cnt_inc;
  logic              w_can_wr, w_own_req, w_prio_en, w_prio_cut;
  logic              w_pick_valid;
  logic [c_PW-1:0]   w_pick_idx;
  logic [NREQ-1:0]   w_gnt;
  logic [DW-1:0]     w_wr_data;

  // Only grant when the write is certain to land; reset also masks grants.
  assign w_can_wr  = !bus.fifo_full && !bus.fifo_rd && !rst;
  assign w_own_req = bus.req[r_owner];
  assign w_cnt_inc = r_beat_cnt + 1'b1;

`ifdef FIFO_ARB_PRIO_EN
  assign w_prio_en  = 1'b1;
  assign w_prio_cut = bus.req[0] && (r_owner != '0);
`else
  assign w_prio_en  = 1'b0;
  assign w_prio_cut = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ), .PW(c_PW)) u_pick (
    .i_req     (bus.req),
    .i_rr_ptr  (r_rr_ptr),
    .i_prio_en (w_prio_en),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_beat_cnt;
    if (w_can_wr) begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            w_owner_nxt = w_pick_idx;
            if (BURST_LEN == 1) begin
              w_rr_nxt = c_PW'(next_rr(int'(w_pick_idx), NREQ));
            end else begin
              w_state_nxt = BURST;
              w_cnt_nxt   = c_CW'(1);
            end
          end
        end
        BURST: begin
          // A dropped req, a full burst or a priority cut all hand over at owner+1.
          if (!w_own_req || w_prio_cut || (w_cnt_inc == c_CW'(BURST_LEN))) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = c_PW'(next_rr(int'(r_owner), NREQ));
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_can_wr) begin
      case (r_state)
        IDLE:    if (w_pick_valid) w_gnt[w_pick_idx] = 1'b1;
        BURST:   w_gnt[r_owner] = w_own_req;
        default: w_gnt = '0;
      endcase
    end
    w_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_wr_data = bus.req_data[i*DW +: DW];
    end
  end

  assign bus.gnt          = w_gnt;
  assign bus.fifo_wr      = |(bus.req & w_gnt);
  assign bus.fifo_wr_data = w_wr_data;
  assign bus.owner        = r_owner;
  assign bus.busy         = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_wr_arb : directed vector bench with a byte-FIFO model        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_fifo_wr_arb;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rd;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  logic        clk = 1'b0;
  logic        r_rst = 1'b1;
  logic [3:0]  r_req = 4'h0;
  logic        r_rd = 1'b0;
  logic [31:0] rdata;
  int          n_err = 0;
  int          n_chk = 0;

  // FIFO model state, written only by the model process.
  logic [7:0]  fq[$];
  logic [7:0]  wlog[$];
  int          fcnt = 0;
  int          beat_no[4] = '{0, 0, 0, 0};
  int          lost = 0;
  int          r_fill = -1;
  vec_t        vt[$];

  fifo_wr_arb_if #(.NREQ(4), .DW(8)) bus();

  fifo_wr_arb #(.NREQ(4), .DW(8), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (r_rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.req       = r_req;
  assign bus.req_data  = rdata;
  assign bus.fifo_rd   = r_rd;
  assign bus.fifo_full = (fcnt >= 31);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[i*8 +: 8] = {4'(i), 4'(beat_no[i])};
  end

  always @(posedge clk) begin
    if (r_fill >= 0) begin
      fq.delete();
      for (int i = 0; i < r_fill; i++) fq.push_back(8'hEE);
    end else begin
      if (bus.fifo_wr && (bus.fifo_full || bus.fifo_rd)) lost++;
      if (bus.fifo_rd) begin
        if (fq.size() > 0) void'(fq.pop_front());
      end else if (bus.fifo_wr && !bus.fifo_full) begin
        fq.push_back(bus.fifo_wr_data);
        wlog.push_back(bus.fifo_wr_data);
      end
    end
    fcnt <= fq.size();
    for (int i = 0; i < 4; i++) if (r_req[i] && bus.gnt[i]) beat_no[i] <= beat_no[i] + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s_rst, input logic [3:0] s_req, input logic s_rd);
    @(negedge clk);
    r_rst = s_rst;
    r_req = s_req;
    r_rd  = s_rd;
    #1;
  endtask

  task automatic rst_fill(input int lvl);
    @(negedge clk);
    r_rst  = 1'b1;
    r_req  = 4'h0;
    r_rd   = 1'b0;
    r_fill = lvl;
    @(negedge clk);
    r_fill = -1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] eg, input logic eb, input logic [1:0] eo);
    logic [7:0] ed;
    ed = '0;
    for (int i = 0; i < 4; i++) if (eg[i]) ed = rdata[i*8 +: 8];
    chk({nm, ".gnt"},   bus.gnt, eg);
    chk({nm, ".wr"},    bus.fifo_wr, |(r_req & eg));
    chk({nm, ".wdata"}, bus.fifo_wr_data, ed);
    chk({nm, ".busy"},  bus.busy, eb);
    chk({nm, ".owner"}, bus.owner, eo);
  endtask

  task automatic add(input logic a, input logic [3:0] b, input logic c,
                     input logic [3:0] d, input logic e, input logic [1:0] f);
    vec_t v;
    v.rst = a; v.req = b; v.rd = c; v.gnt = d; v.busy = e; v.owner = f;
    vt.push_back(v);
  endtask

  initial begin
    int b2;
`ifndef FIFO_ARB_PRIO_EN
    // Reset, full rotation with an rd stall inside requester 1's burst, then a dropped burst.
    add(1, 4'hF, 0, 4'h0, 0, 0); add(1, 4'hF, 0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 4'h1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 4'h1, 1, 0);
    add(0, 4'hF, 0, 4'h2, 0, 0); add(0, 4'hF, 0, 4'h2, 1, 1);
    add(0, 4'hF, 1, 4'h0, 1, 1); add(0, 4'hF, 1, 4'h0, 1, 1);
    add(0, 4'hF, 0, 4'h2, 1, 1); add(0, 4'hF, 0, 4'h2, 1, 1);
    add(0, 4'hF, 0, 4'h4, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 4'h4, 1, 2);
    add(0, 4'hF, 0, 4'h8, 0, 2);
    for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 4'h8, 1, 3);
    add(0, 4'h0, 0, 4'h0, 0, 3);
    add(0, 4'h8, 0, 4'h8, 0, 3); add(0, 4'h8, 0, 4'h8, 1, 3);
    add(0, 4'h7, 0, 4'h0, 1, 3);
    add(0, 4'hF, 0, 4'h1, 0, 3);
    for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 4'h1, 1, 0);
    add(0, 4'hF, 0, 4'h2, 0, 0);
    add(0, 4'h0, 0, 4'h0, 1, 1);

    for (int k = 0; k < vt.size(); k++) begin
      step(vt[k].rst, vt[k].req, vt[k].rd);
      chk_out($sformatf("row%0d", k), vt[k].gnt, vt[k].busy, vt[k].owner);
    end
    @(negedge clk);
    chk("wlog_size", wlog.size(), 23);
    for (int i = 0; i < 16; i++) chk($sformatf("order%0d", i), wlog[i], {4'(i / 4), 4'(i % 4)});
    chk("order_r3_resume", wlog[16], 8'h34);
    chk("fifo_count", fcnt, 21);
`endif

    // Reset mid-burst abandons the burst and restarts at requester 0.
    rst_fill(0);
    step(0, 4'h4, 0); chk_out("mr_first", 4'h4, 0, 0);
    step(0, 4'h4, 0); chk_out("mr_burst", 4'h4, 1, 2);
    step(1, 4'hF, 0); chk_out("mr_inrst", 4'h0, 1, 2);
    step(0, 4'hF, 0); chk_out("mr_after", 4'h1, 0, 0);

`ifdef FIFO_ARB_PRIO_EN
    rst_fill(0);
    step(0, 4'h4, 0); chk_out("pr_b1", 4'h4, 0, 0);
    step(0, 4'h5, 0); chk_out("pr_b2", 4'h4, 1, 2);
    step(0, 4'h9, 0); chk_out("pr_r0", 4'h1, 0, 2);
    for (int k = 0; k < 3; k++) begin
      step(0, 4'h9, 0); chk_out($sformatf("pr_r0b%0d", k), 4'h1, 1, 0);
    end
    step(0, 4'h8, 0); chk_out("pr_r3", 4'h8, 0, 0);
`endif

    // Near-full FIFO: 30 entries admit one beat, a single read admits one more.
    rst_fill(30);
    step(0, 4'h0, 0); chk("full_pre", bus.fifo_full, 1'b0);
    b2 = beat_no[2];
    step(0, 4'h4, 0); chk_out("full_b1", 4'h4, 0, 0);
    step(0, 4'h4, 0); chk_out("full_stall1", 4'h0, 1, 2);
    chk("full_flag", bus.fifo_full, 1'b1);
    step(0, 4'h4, 0); chk_out("full_stall2", 4'h0, 1, 2);
    step(0, 4'h4, 1); chk_out("full_rd", 4'h0, 1, 2);
    step(0, 4'h4, 0); chk_out("full_b2", 4'h4, 1, 2);
    step(0, 4'h4, 0); chk_out("full_stall3", 4'h0, 1, 2);
    chk("full_beats", beat_no[2] - b2, 2);
    chk("full_count", fcnt, 31);
    chk("no_lost_wr", lost, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
Round-robin, burst-capable arbiter that shares the single write port of the 32-deep byte FIFO among NREQ producers. Each producer uses a req/gnt handshake; the arbiter drives the FIFO wr/wr_data pins.
The FIFO drops a write when rd is asserted in the same cycle, and refuses writes when full. The arbiter therefore grants only when the write will actually land, so no beat is ever lost.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width; must equal the FIFO data width
BURST_LEN, 4, maximum beats one owner may write before re-arbitration (1..16)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester write request; data valid while high
req_data  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW]
gnt  out  NREQ  one-hot grant (combinational); beat i transfers when req[i] && gnt[i] at the clock edge
fifo_wr  out  1  to FIFO wr
fifo_wr_data  out  DW  to FIFO wr_data
fifo_full  in  1  from FIFO full (asserted at 31 entries)
fifo_rd  in  1  copy of the rd pin driven into the FIFO by the consumer
owner  out  clog2(NREQ)  current/last burst owner, registered
busy  out  1  high in BURST state

Behaviour:
- can_wr = !fifo_full && !fifo_rd. When can_wr=0, gnt=0 and fifo_wr=0; the state, beat counter and RR pointer hold.
- fifo_wr = |(req & gnt). fifo_wr_data = req_data slice of the granted requester, or 0 when no grant.
- Zero-cycle latency: a beat is accepted in the same cycle gnt is asserted.
- State IDLE:
  - Candidate = first i with req[i]=1, scanning from rr_ptr upward with wrap at NREQ.
  - If a candidate exists and can_wr=1: gnt[candidate]=1 and owner<=candidate.
    - BURST_LEN==1: stay in IDLE; rr_ptr<=candidate+1 (mod NREQ).
    - Otherwise: go to BURST with beat_cnt<=1.
- State BURST:
  - gnt[owner]=req[owner]&&can_wr; all other gnt bits are 0.
  - Accepted beat: beat_cnt++. If beat_cnt+1==BURST_LEN, go to IDLE and set rr_ptr<=owner+1.
  - req[owner]=0: go to IDLE, rr_ptr<=owner+1, no grant that cycle (one dead cycle).
- Stall inside a burst (full or rd): the burst is kept and beat_cnt holds.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, busy=0. gnt, fifo_wr and fifo_wr_data are 0 while rst=1, regardless of req.
- rst asserted mid-burst: the burst is abandoned; the next cycle after release arbitrates from requester 0.
- A requester must keep req_data stable while req=1 and no gnt has been received.
- Width rules: beat_cnt is clog2(BURST_LEN+1) bits; rr_ptr is clog2(NREQ) bits with explicit mod-NREQ wrap (NREQ need not be a power of 2).

Optional Feature:
FIFO_ARB_PRIO_EN:
- Defined: requester 0 is strict-high-priority.
  - In IDLE, if req[0]=1 it wins regardless of rr_ptr.
  - In BURST owned by another requester, req[0]=1 ends that burst after its current beat: go to IDLE, rr_ptr<=owner+1.
  - Requester 0 bursts still respect BURST_LEN.
- Undefined: pure round-robin as above.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - function next_rr(ptr, NREQ)
  - FIFO_DEPTH=32
  - FIFO_FULL_LVL=31
- One natural sub-module: rr_pick. It is combinational: given req, rr_ptr and prio_en, it returns a valid flag and an index.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, fifo_wr=0, busy=0. First grant after release goes to requester 0.
- All four requesting, BURST_LEN=4, FIFO empty, fifo_rd=0 -> grant order 0×4, 1×4, 2×4, 3×4. FIFO holds 16 bytes in that order.
- fifo_rd=1 for 2 cycles mid-burst of requester 1 after beat 2 -> gnt=0 for those cycles, beat_cnt holds at 2. Burst completes 2 more beats afterward, with no write lost and FIFO count correct.
- Preload FIFO to 30 entries, requester 2 requests 3 beats -> exactly 1 beat accepted, then fifo_full=1 forces gnt=0. One FIFO read releases exactly 1 more beat.
- Requester 3 drops req after 2 beats of a 4-beat burst -> one dead cycle, then requester 0 (next after 3, wrapped) is granted. Requester 3 is not re-granted ahead of 0,1,2.
- With FIFO_ARB_PRIO_EN, requester 2 in burst and req[0] rising at beat 1 -> requester 2 gets 2 beats total, then requester 0 is granted, then arbitration resumes at requester 3.
